// File: rtl/cv32e40x_div_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Uses the ALU's CLZ and shifter to normalise the divisor, then does one subtract-and-shift step per cycle.
module cv32e40x_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        alu_clz_en_o,
  output logic [31:0] alu_clz_data_rev_o,
  input  logic [5:0]  alu_clz_result_i,
  output logic        alu_shift_en_o,
  output logic [5:0]  alu_shift_amt_o,
  output logic [31:0] alu_op_b_o,
  input  logic [31:0] alu_op_b_shifted_i
);

  typedef enum logic [1:0] {IDLE, INIT, DIVIDE, FINISH} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_abs_q, a_abs_d;
  logic [31:0] b_abs_q, b_abs_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  logic        in_signed;
  logic        rem_ge;
  logic [31:0] rem_nx;
  logic [31:0] quot_nx;
  logic        b_zero;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Sign flags are stored already qualified by signedness, so they drive the fix-up directly.
  function automatic logic [31:0] fixup(input logic is_rem, input logic sa, input logic sb,
                                        input logic [31:0] q, input logic [31:0] r);
    if (is_rem) return sa ? negate(r) : r;
    return (sa ^ sb) ? negate(q) : q;
  endfunction

  assign in_signed = ~operator_i[0];
  assign rem_ge    = (rem_q >= dvsr_q);
  assign rem_nx    = rem_ge ? (rem_q - dvsr_q) : rem_q;
  assign quot_nx   = (quot_q << 1) | {31'd0, rem_ge};
  // The ALU reports 32 only for an all-zero input, i.e. a zero divisor.
  assign b_zero    = (b_abs_q == 32'd0) | alu_clz_result_i[5];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_abs_d  = a_abs_q;
    b_abs_d  = b_abs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    ready_o            = (state_q == IDLE);
    valid_o            = (state_q == FINISH);
    alu_clz_en_o       = 1'b0;
    alu_clz_data_rev_o = 32'd0;
    alu_shift_en_o     = 1'b0;
    alu_shift_amt_o    = 6'd0;
    alu_op_b_o         = 32'd0;

    case (state_q)
      IDLE: begin
        if (valid_i && !kill_i) begin
          op_d     = operator_i;
          sign_a_d = in_signed & op_a_i[31];
          sign_b_d = in_signed & op_b_i[31];
          a_abs_d  = (in_signed & op_a_i[31]) ? negate(op_a_i) : op_a_i;
          b_abs_d  = (in_signed & op_b_i[31]) ? negate(op_b_i) : op_b_i;
          state_d  = INIT;
        end
      end
      INIT: begin
        alu_clz_en_o       = 1'b1;
        alu_clz_data_rev_o = bit_rev(b_abs_q);
        alu_shift_en_o     = 1'b1;
        alu_shift_amt_o    = {1'b0, alu_clz_result_i[4:0]};
        alu_op_b_o         = b_abs_q;
        rem_d              = a_abs_q;
        dvsr_d             = alu_op_b_shifted_i;
        cnt_d              = alu_clz_result_i[4:0];
        quot_d             = 32'd0;
        if (b_zero) begin
          // Re-negating |a| restores the original dividend for signed REM.
          result_d = op_q[1] ? (sign_a_q ? negate(a_abs_q) : a_abs_q) : 32'hFFFF_FFFF;
          state_d  = FINISH;
        end else begin
          state_d  = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        dvsr_d = dvsr_q >> 1;
        if (cnt_q == 5'd0) begin
          result_d = fixup(op_q[1], sign_a_q, sign_b_q, quot_nx, rem_nx);
          state_d  = FINISH;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FINISH: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      a_abs_q  <= 32'd0;
      b_abs_q  <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      quot_q   <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_abs_q  <= a_abs_d;
      b_abs_q  <= b_abs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// Bench for cv32e40x_div_seq: ALU CLZ/shift model, arithmetic reference model and per-cycle compare.
module tb_cv32e40x_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  operator_i = 2'd0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        alu_clz_en_o;
  logic [31:0] alu_clz_data_rev_o;
  logic [5:0]  alu_clz_result;
  logic        alu_shift_en_o;
  logic [5:0]  alu_shift_amt_o;
  logic [31:0] alu_op_b_o;
  logic [31:0] alu_op_b_shifted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int n;
  logic        active = 1'b0;
  int          exp_lat;
  logic [31:0] exp_res, exp_mag, exp_rev;
  logic [5:0]  exp_amt;

  cv32e40x_div_seq dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .alu_clz_en_o(alu_clz_en_o), .alu_clz_data_rev_o(alu_clz_data_rev_o),
    .alu_clz_result_i(alu_clz_result), .alu_shift_en_o(alu_shift_en_o),
    .alu_shift_amt_o(alu_shift_amt_o), .alu_op_b_o(alu_op_b_o),
    .alu_op_b_shifted_i(alu_op_b_shifted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU side: trailing zeros of the reversed data equals leading zeros of the divisor.
  always_comb begin
    alu_clz_result = 6'd0;
    if (alu_clz_en_o) begin
      alu_clz_result = 6'd32;
      for (int i = 31; i >= 0; i--) if (alu_clz_data_rev_o[i]) alu_clz_result = 6'(i);
    end
  end
  assign alu_op_b_shifted = alu_shift_en_o ? (alu_op_b_o << alu_shift_amt_o) : 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lzc(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      2'd1: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic set_expect(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_res = model_res(op, a, b);
    exp_mag = (!op[0] && b[31]) ? -b : b;
    for (int i = 0; i < 32; i++) exp_rev[i] = exp_mag[31-i];
    exp_lat = (exp_mag == 32'd0) ? 2 : 3 + lzc(exp_mag);
    exp_amt = (exp_mag == 32'd0) ? 6'd0 : 6'(lzc(exp_mag));
  endtask

  // Per-cycle compare against the model while an operation is in flight.
  always @(negedge clk) begin
    if (active) begin
      n = cyc - t0;
      chk1("valid_o", valid_o, n >= exp_lat);
      if (n >= exp_lat) chk("result_o", result_o, exp_res);
      chk1("ready_o", ready_o, n == 0);
      chk1("clz_en", alu_clz_en_o, n == 1);
      chk1("shift_en", alu_shift_en_o, n == 1);
      if (n == 1) begin
        chk("clz_data_rev", alu_clz_data_rev_o, exp_rev);
        chk("shift_amt", {26'd0, alu_shift_amt_o}, {26'd0, exp_amt});
        chk("alu_op_b", alu_op_b_o, exp_mag);
      end
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    set_expect(op, a, b);
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    valid_i    = 1'b1;
    t0         = cyc;
    active     = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit_res, input int lit_lat, input int stall);
    int k;
    set_expect(op, a, b);
    chk({name, "_model_res"}, exp_res, lit_res);
    chk({name, "_model_lat"}, 32'(exp_lat), 32'(lit_lat));
    ready_i = (stall == 0);
    launch(op, a, b);
    k = 0;
    while (!valid_o && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_valid required=valid_in_%0d_cycles", name, exp_lat);
      active  = 1'b0;
      kill_i  = 1'b1;
      ready_i = 1'b1;
      @(posedge clk); #1;
      kill_i = 1'b0;
      return;
    end
    chk({name, "_latency"}, 32'(k + 1), 32'(exp_lat));
    if (stall > 0) begin
      operator_i = 2'd1;
      op_a_i     = 32'd5;
      op_b_i     = 32'd1;
      valid_i    = 1'b1;
      repeat (stall) begin @(posedge clk); #1; end
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(posedge clk); #1;
    active = 1'b0;
    chk1({name, "_valid_drop"}, valid_o, 1'b0);
    chk1({name, "_idle_ready"}, ready_o, 1'b1);
    chk1({name, "_no_restart"}, alu_clz_en_o, 1'b0);
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready", ready_o, 1'b1);
    chk1("rst_valid", valid_o, 1'b0);
    chk("rst_result", result_o, 32'd0);
    chk1("rst_clz_en", alu_clz_en_o, 1'b0);
    chk1("rst_shift_en", alu_shift_en_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7",   2'd1, 32'd100,         32'd7,          32'd14,          32, 0);
    run_op("remu_100_7",   2'd3, 32'd100,         32'd7,          32'd2,           32, 0);
    run_op("div_m7_2",     2'd0, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD,   33, 0);
    run_op("rem_m7_2",     2'd2, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFF,   33, 0);
    run_op("div_7_m2",     2'd0, 32'd7,           32'hFFFF_FFFE,  32'hFFFF_FFFD,   33, 0);
    run_op("rem_7_m2",     2'd2, 32'd7,           32'hFFFF_FFFE,  32'd1,           33, 0);
    run_op("div_ovf",      2'd0, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,   34, 0);
    run_op("rem_ovf",      2'd2, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,           34, 0);
    run_op("divu_max_1",   2'd1, 32'hFFFF_FFFF,   32'd1,          32'hFFFF_FFFF,   34, 0);
    run_op("divu_msb",     2'd1, 32'h8000_0000,   32'h8000_0000,  32'd1,           3,  0);
    run_op("divu_dbz",     2'd1, 32'h0000_1234,   32'd0,          32'hFFFF_FFFF,   2,  0);
    run_op("rem_dbz",      2'd2, 32'h0000_1234,   32'd0,          32'h0000_1234,   2,  0);
    run_op("rem_dbz_neg",  2'd2, 32'hFFFF_FF9C,   32'd0,          32'hFFFF_FF9C,   2,  0);
    run_op("stall_1000_3", 2'd1, 32'd1000,        32'd3,          32'd333,         33, 5);

    // Abort in the fourth DIVIDE cycle.
    ready_i = 1'b1;
    launch(2'd1, 32'd1000, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    active = 1'b0;
    chk1("kill_ready", ready_o, 1'b1);
    chk1("kill_valid", valid_o, 1'b0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o || !ready_o) bad++;
    end
    chk("kill_no_result", 32'(bad), 32'd0);

    // A request alongside kill_i is not accepted.
    @(posedge clk); #1;
    operator_i = 2'd1;
    op_a_i     = 32'd9;
    op_b_i     = 32'd3;
    valid_i    = 1'b1;
    kill_i     = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    chk1("kill_blocks_accept", ready_o, 1'b1);
    chk1("kill_blocks_init", alu_clz_en_o, 1'b0);

    run_op("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 33, 0);

    // Asynchronous reset in the middle of DIVIDE.
    launch(2'd1, 32'd1000, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    #2;
    active = 1'b0;
    rst    = 1'b1;
    #1;
    chk1("arst_ready", ready_o, 1'b1);
    chk1("arst_valid", valid_o, 1'b0);
    chk("arst_result", result_o, 32'd0);
    chk1("arst_clz_en", alu_clz_en_o, 1'b0);
    chk1("arst_shift_en", alu_shift_en_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("after_rst", 2'd3, 32'd100, 32'd7, 32'd2, 32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
